// File: rtl/rf_pkg.sv
// Register-file constants shared by decode, writeback and the register file itself.
// Pure definitions: no logic, no latency, no flow control.
package rf_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int ZERO_ADDR  = 0;

   function automatic int num_regs(input int addr_w);
      return 1 << addr_w;
   endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bundle for the register file: read ports, two write ports, busy mark.
// Read data and busy are zero-latency; no backpressure, every request is accepted.
interface regfile_mp_if import rf_pkg::*; #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_READ = 2
);
   logic [NUM_READ*ADDR_W-1:0] readReg;
   logic [NUM_READ*DATA_W-1:0] readData;
   logic [NUM_READ-1:0]        readBusy;
   logic [ADDR_W-1:0]          writeReg0;
   logic [DATA_W-1:0]          writeData0;
   logic                       RegWrite0;
   logic [ADDR_W-1:0]          writeReg1;
   logic [DATA_W-1:0]          writeData1;
   logic                       RegWrite1;
   logic [ADDR_W-1:0]          markReg;
   logic                       markValid;

   modport master (
      output readReg, writeReg0, writeData0, RegWrite0,
             writeReg1, writeData1, RegWrite1, markReg, markValid,
      input  readData, readBusy
   );

   modport slave (
      input  readReg, writeReg0, writeData0, RegWrite0,
             writeReg1, writeData1, RegWrite1, markReg, markValid,
      output readData, readBusy
   );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write flags: writes clear, marks set (mark wins), sync reset clears all.
// Lookups are registered state only (no bypass); updates take effect one edge later; no backpressure.
module rf_scoreboard import rf_pkg::*; #(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_READ = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clr0_vld_i,
   input  logic [ADDR_W-1:0]          clr0_addr_i,
   input  logic                       clr1_vld_i,
   input  logic [ADDR_W-1:0]          clr1_addr_i,
   input  logic                       mark_vld_i,
   input  logic [ADDR_W-1:0]          mark_addr_i,
   input  logic [NUM_READ*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_READ-1:0]        rd_busy_o
);
   localparam int                NUM_REGS = num_regs(ADDR_W);
   localparam logic [ADDR_W-1:0] ZA       = ADDR_W'(ZERO_ADDR);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // Mark applied last: a newer producer overrides the retiring write.
   always_comb begin
      busy_d = busy_q;
      if (clr0_vld_i) busy_d[clr0_addr_i] = 1'b0;
      if (clr1_vld_i) busy_d[clr1_addr_i] = 1'b0;
      if (mark_vld_i) busy_d[mark_addr_i] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_lookup
      logic [ADDR_W-1:0] addr;
      assign addr         = rd_addr_i[i*ADDR_W +: ADDR_W];
      assign rd_busy_o[i] = (ZERO_REG && addr == ZA) ? 1'b0 : busy_q[addr];
   end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_READ combinational reads with write bypass, two write ports, busy scoreboard.
// Reads zero-latency, writes commit on the rising edge; no backpressure, all requests accepted.
module regfile_mp import rf_pkg::*; #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_READ = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic         CLK,
   input  logic         RST,
   regfile_mp_if.slave  rf
);
   localparam int                NUM_REGS = num_regs(ADDR_W);
   localparam logic [ADDR_W-1:0] ZA       = ADDR_W'(ZERO_ADDR);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              wr0_vld;
   logic              wr1_vld;
   logic              mark_vld;

   // Traffic to the hardwired zero register is filtered once here for both data and busy state.
   assign wr0_vld  = rf.RegWrite0 && !(ZERO_REG && rf.writeReg0 == ZA);
   assign wr1_vld  = rf.RegWrite1 && !(ZERO_REG && rf.writeReg1 == ZA);
   assign mark_vld = rf.markValid && !(ZERO_REG && rf.markReg == ZA);

   always_comb begin
      regs_d = regs_q;
      if (wr0_vld) regs_d[rf.writeReg0] = rf.writeData0;
      if (wr1_vld) regs_d[rf.writeReg1] = rf.writeData1;
   end

   always_ff @(posedge CLK) begin
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_q[r] <= RST ? '0 : regs_d[r];
      end
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = rf.readReg[i*ADDR_W +: ADDR_W];

      always_comb begin
         if (ZERO_REG && addr == ZA)                          data = '0;
         else if (!RST && rf.RegWrite1 && rf.writeReg1 == addr) data = rf.writeData1;
         else if (!RST && rf.RegWrite0 && rf.writeReg0 == addr) data = rf.writeData0;
         else                                                 data = regs_q[addr];
      end

      assign rf.readData[i*DATA_W +: DATA_W] = data;
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_READ (NUM_READ),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk_i       (CLK),
      .rst_i       (RST),
      .clr0_vld_i  (wr0_vld),
      .clr0_addr_i (rf.writeReg0),
      .clr1_vld_i  (wr1_vld),
      .clr1_addr_i (rf.writeReg1),
      .mark_vld_i  (mark_vld),
      .mark_addr_i (rf.markReg),
      .rd_addr_i   (rf.readReg),
      .rd_busy_o   (rf.readBusy)
   );
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed cases on 32-bit instances (zero register on and off),
// then a random stream with mid-stream reset on a 4-read-port 64-bit instance.
module tb_regfile_mp;
   import rf_pkg::*;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) ifa ();
   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) ifz ();
   regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NUM_READ(4)) ifw ();

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1'b1)) dut_a (.CLK(CLK), .RST(RST), .rf(ifa));
   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1'b0)) dut_z (.CLK(CLK), .RST(RST), .rf(ifz));
   regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_READ(4), .ZERO_REG(1'b1)) dut_w (.CLK(CLK), .RST(RST), .rf(ifw));

   // The ZERO_REG=0 instance sees exactly the same stimulus as the default one.
   assign ifz.readReg    = ifa.readReg;
   assign ifz.writeReg0  = ifa.writeReg0;
   assign ifz.writeData0 = ifa.writeData0;
   assign ifz.RegWrite0  = ifa.RegWrite0;
   assign ifz.writeReg1  = ifa.writeReg1;
   assign ifz.writeData1 = ifa.writeData1;
   assign ifz.RegWrite1  = ifa.RegWrite1;
   assign ifz.markReg    = ifa.markReg;
   assign ifz.markValid  = ifa.markValid;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic [63:0] m_reg  [32];
   logic        m_busy [32];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [63:0] act);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 64'(exp_q.size()), 64'd1);
      end else begin
         e = exp_q.pop_front();
         chk(e.tag, act, e.val);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      @(negedge CLK);
   endtask

   task automatic idle();
      ifa.RegWrite0 = 1'b0;
      ifa.RegWrite1 = 1'b0;
      ifa.markValid = 1'b0;
      ifw.RegWrite0 = 1'b0;
      ifw.RegWrite1 = 1'b0;
      ifw.markValid = 1'b0;
   endtask

   function automatic logic [4:0] pick();
      return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
   endfunction

   initial begin
      RST = 1'b1;
      ifa.readReg = '0;  ifa.writeReg0 = '0; ifa.writeData0 = '0;
      ifa.writeReg1 = '0; ifa.writeData1 = '0; ifa.markReg = '0;
      ifw.readReg = '0;  ifw.writeReg0 = '0; ifw.writeData0 = '0;
      ifw.writeReg1 = '0; ifw.writeData1 = '0; ifw.markReg = '0;
      idle();
      tick();
      tick();
      RST = 1'b0;

      // Reset state
      ifa.readReg = {5'd5, 5'd5};
      ifw.readReg = {5'd31, 5'd17, 5'd5, 5'd1};
      sb_push("rst_a_data", 64'd0);
      sb_push("rst_a_busy", 64'd0);
      sb_push("rst_z_data", 64'd0);
      for (int i = 0; i < 4; i++) sb_push($sformatf("rst_w_data%0d", i), 64'd0);
      settle();
      sb_pop(64'(ifa.readData[31:0]));
      sb_pop(64'(ifa.readBusy[1]));
      sb_pop(64'(ifz.readData[31:0]));
      for (int i = 0; i < 4; i++) sb_pop(ifw.readData[i*64 +: 64]);

      // 1: write reg5, then reset while a (to-be-ignored) write is driven
      tick();
      ifa.RegWrite0 = 1'b1; ifa.writeReg0 = 5'd5; ifa.writeData0 = 32'hDEADBEEF;
      sb_push("t1_bypass", 64'hDEADBEEF);
      settle();
      sb_pop(64'(ifa.readData[31:0]));
      tick();
      RST = 1'b1;
      ifa.writeData0 = 32'h0000_1234;
      ifa.markValid = 1'b1; ifa.markReg = 5'd5;
      sb_push("t1_rst_no_bypass", 64'hDEADBEEF);
      settle();
      sb_pop(64'(ifa.readData[31:0]));
      tick();
      RST = 1'b0;
      idle();
      sb_push("t1_after_rst_data", 64'd0);
      sb_push("t1_after_rst_busy", 64'd0);
      settle();
      sb_pop(64'(ifa.readData[31:0]));
      sb_pop(64'(ifa.readBusy[0]));

      // 2: same-cycle write/read bypass on port 0, then stored value
      tick();
      ifa.readReg = {5'd0, 5'd3};
      ifa.RegWrite0 = 1'b1; ifa.writeReg0 = 5'd3; ifa.writeData0 = 32'h11;
      sb_push("t2_bypass", 64'h11);
      settle();
      sb_pop(64'(ifa.readData[31:0]));
      tick();
      idle();
      sb_push("t2_stored", 64'h11);
      settle();
      sb_pop(64'(ifa.readData[31:0]));

      // 3: both ports write reg7, port 1 wins
      tick();
      ifa.readReg = {5'd7, 5'd3};
      ifa.RegWrite0 = 1'b1; ifa.writeReg0 = 5'd7; ifa.writeData0 = 32'hAA;
      ifa.RegWrite1 = 1'b1; ifa.writeReg1 = 5'd7; ifa.writeData1 = 32'hBB;
      sb_push("t3_bypass", 64'hBB);
      settle();
      sb_pop(64'(ifa.readData[63:32]));
      tick();
      idle();
      sb_push("t3_stored", 64'hBB);
      sb_push("t3_other_reg", 64'h11);
      settle();
      sb_pop(64'(ifa.readData[63:32]));
      sb_pop(64'(ifa.readData[31:0]));

      // 4: write and mark reg0; hardwired on dut_a, ordinary on dut_z
      tick();
      ifa.readReg = {5'd0, 5'd0};
      ifa.RegWrite0 = 1'b1; ifa.writeReg0 = 5'd0; ifa.writeData0 = 32'hFFFF_FFFF;
      ifa.markValid = 1'b1; ifa.markReg = 5'd0;
      sb_push("t4_a_data_now", 64'd0);
      sb_push("t4_a_busy_now", 64'd0);
      sb_push("t4_z_data_now", 64'hFFFF_FFFF);
      sb_push("t4_z_busy_now", 64'd0);
      settle();
      sb_pop(64'(ifa.readData[31:0]));
      sb_pop(64'(ifa.readBusy[0]));
      sb_pop(64'(ifz.readData[31:0]));
      sb_pop(64'(ifz.readBusy[0]));
      tick();
      idle();
      sb_push("t4_a_data", 64'd0);
      sb_push("t4_a_busy", 64'd0);
      sb_push("t4_z_data", 64'hFFFF_FFFF);
      sb_push("t4_z_busy", 64'd1);
      settle();
      sb_pop(64'(ifa.readData[31:0]));
      sb_pop(64'(ifa.readBusy[0]));
      sb_pop(64'(ifz.readData[31:0]));
      sb_pop(64'(ifz.readBusy[0]));

      // 5: busy scoreboard on reg9 via read port 1
      tick();
      ifa.readReg = {5'd9, 5'd0};
      ifa.markValid = 1'b1; ifa.markReg = 5'd9;
      sb_push("t5_mark_same_cycle", 64'd0);
      settle();
      sb_pop(64'(ifa.readBusy[1]));
      for (int k = 0; k < 2; k++) begin
         tick();
         idle();
         sb_push($sformatf("t5_busy_hold%0d", k), 64'd1);
         settle();
         sb_pop(64'(ifa.readBusy[1]));
      end
      tick();
      ifa.RegWrite0 = 1'b1; ifa.writeReg0 = 5'd9; ifa.writeData0 = 32'h42;
      sb_push("t5_wr_data_now", 64'h42);
      sb_push("t5_wr_busy_now", 64'd1);
      settle();
      sb_pop(64'(ifa.readData[63:32]));
      sb_pop(64'(ifa.readBusy[1]));
      tick();
      idle();
      sb_push("t5_wr_data", 64'h42);
      sb_push("t5_wr_busy", 64'd0);
      settle();
      sb_pop(64'(ifa.readData[63:32]));
      sb_pop(64'(ifa.readBusy[1]));
      tick();
      ifa.RegWrite1 = 1'b1; ifa.writeReg1 = 5'd9; ifa.writeData1 = 32'h77;
      ifa.markValid = 1'b1; ifa.markReg = 5'd9;
      sb_push("t5_mw_data_now", 64'h77);
      sb_push("t5_mw_busy_now", 64'd0);
      settle();
      sb_pop(64'(ifa.readData[63:32]));
      sb_pop(64'(ifa.readBusy[1]));
      tick();
      idle();
      sb_push("t5_mw_data", 64'h77);
      sb_push("t5_mw_busy", 64'd1);
      settle();
      sb_pop(64'(ifa.readData[63:32]));
      sb_pop(64'(ifa.readBusy[1]));
      tick();
      ifa.markValid = 1'b1; ifa.markReg = 5'd9;
      tick();
      idle();
      sb_push("t5_remark_busy", 64'd1);
      settle();
      sb_pop(64'(ifa.readBusy[1]));

      // 6: random traffic against a reference model, reset at cycle 500
      begin : rnd
         logic        rr, we0, we1, mv;
         logic [4:0]  wa0, wa1, ma;
         logic [63:0] wd0, wd1, e;
         logic [4:0]  ra [4];

         for (int r = 0; r < 32; r++) begin
            m_reg[r]  = 64'd0;
            m_busy[r] = 1'b0;
         end
         for (int cyc = 0; cyc < 1000; cyc++) begin
            tick();
            rr  = (cyc == 500);
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            mv  = 1'($urandom_range(0, 1));
            wa0 = pick(); wa1 = pick(); ma = pick();
            wd0 = {$urandom, $urandom};
            wd1 = {$urandom, $urandom};
            if (cyc > 500 && cyc <= 508) begin
               we0 = 1'b0; we1 = 1'b0; mv = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
               ra[i] = (cyc > 500 && cyc <= 508) ? 5'((cyc - 501) * 4 + i) : pick();
               ifw.readReg[i*5 +: 5] = ra[i];
            end
            RST = rr;
            ifw.RegWrite0 = we0; ifw.writeReg0 = wa0; ifw.writeData0 = wd0;
            ifw.RegWrite1 = we1; ifw.writeReg1 = wa1; ifw.writeData1 = wd1;
            ifw.markValid = mv;  ifw.markReg = ma;
            for (int i = 0; i < 4; i++) begin
               if (ra[i] == 5'd0)                     e = 64'd0;
               else if (!rr && we1 && wa1 == ra[i])   e = wd1;
               else if (!rr && we0 && wa0 == ra[i])   e = wd0;
               else                                   e = m_reg[ra[i]];
               sb_push($sformatf("rnd%0d_data%0d", cyc, i), e);
            end
            for (int i = 0; i < 4; i++) begin
               sb_push($sformatf("rnd%0d_busy%0d", cyc, i), (ra[i] == 5'd0) ? 64'd0 : 64'(m_busy[ra[i]]));
            end
            settle();
            for (int i = 0; i < 4; i++) sb_pop(ifw.readData[i*64 +: 64]);
            for (int i = 0; i < 4; i++) sb_pop(64'(ifw.readBusy[i]));
            if (rr) begin
               for (int r = 0; r < 32; r++) begin
                  m_reg[r]  = 64'd0;
                  m_busy[r] = 1'b0;
               end
            end else begin
               if (we0 && wa0 != 5'd0) begin m_reg[wa0] = wd0; m_busy[wa0] = 1'b0; end
               if (we1 && wa1 != 5'd0) begin m_reg[wa1] = wd1; m_busy[wa1] = 1'b0; end
               if (mv && ma != 5'd0) m_busy[ma] = 1'b1;
            end
         end
      end

      tick();
      RST = 1'b0;
      idle();
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
